tg_packet_parser: RTL and testbench
===================================

Name: tg_packet_parser

Overview:
- Decodes the ThinkGear byte stream from the headset UART receiver into attention, meditation and signal-quality values.
- Sits directly upstream of the game-parameter stage and drives its attention_data input.
- Runs on the system clock and consumes one byte per rx_valid strobe.
- Commits values only from packets whose checksum verifies, so downstream logic never sees partial or corrupt data.

Parameters:
- MAX_PLEN, 169, largest legal payload length; larger PLEN aborts the packet.
- SYNC_BYTE, 8'hAA, sync and illegal-PLEN marker.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle
- attention_data  output  8  last committed attention value (code 0x04)
- meditation_data  output  8  last committed meditation value (code 0x05)
- poor_signal  output  8  last committed poor-signal value (code 0x02)
- attn_upd  output  1  one-cycle pulse when attention_data is updated
- pkt_ok  output  1  one-cycle pulse per checksum-valid packet
- chk_err  output  1  one-cycle pulse per checksum-failed packet

Behaviour:
- Reset: all data outputs 8'd0, except poor_signal = 8'd200 (no contact). All pulses 0, FSM in SYNC1, accumulators cleared. Reset mid-packet discards the packet with no pulse.
- FSM advances only in cycles with rx_valid=1. Otherwise all state holds and the pulses are 0.
- SYNC1: byte 0xAA -> SYNC2; any other byte -> stay in SYNC1.
- SYNC2: byte 0xAA -> PLEN; any other byte -> SYNC1.
- PLEN:
  - 0xAA -> stay in PLEN (extra sync byte).
  - Value > MAX_PLEN -> SYNC1.
  - 0 -> CHK.
  - Otherwise latch remaining = PLEN, clear sum and excode level, clear all pending-valid flags -> CODE.
- Every payload byte (CODE, VLEN and VALUE states):
  - sum <= sum + byte, mod 256.
  - remaining decrements.
  - When remaining reaches 0 after this byte, next state is CHK, regardless of row position. A truncated row is dropped and does not set a pending flag.
- CODE:
  - 0x55 -> excode level +1 (saturates at 3), stay in CODE.
  - Code < 0x80 -> VALUE, single byte.
  - Code >= 0x80 -> VLEN.
- VLEN: latch vcount = byte. If 0 -> CODE, else -> VALUE.
- VALUE:
  - Single-byte row with excode level 0 and code 0x02, 0x04 or 0x05 -> store to that field's pending register and set its pending flag.
  - Multi-byte row: decrement vcount, stay in VALUE until vcount reaches 0, then -> CODE. Contents are ignored.
  - Excode level resets to 0 at the end of every row.
- A repeated code in one packet: last value wins.
- CHK: expected checksum = ~sum.
  - Match: in the next cycle, copy each pending field to its output, pulse pkt_ok, and pulse attn_upd if the attention pending flag was set.
  - Mismatch: pulse chk_err; outputs hold.
  - Either way -> SYNC1.
- Latency: outputs and pulses change in the cycle after the rx_valid cycle carrying the checksum byte.
- All outputs are registered. No combinational path from rx_data to any output.

Decomposition:
- Package snake_tg_pkg holds:
  - state enum (SYNC1, SYNC2, PLEN, CODE, VLEN, VALUE, CHK)
  - constants SYNC_BYTE=8'hAA, EXCODE=8'h55, CODE_POOR=8'h02, CODE_ATTN=8'h04, CODE_MED=8'h05, MULTI_BYTE_MIN=8'h80, MAX_PLEN=169, POOR_RESET=8'd200
- Single flat module; no sub-module is warranted. The UART receiver remains a separate existing block.

Test Plan:
- Reset, then bytes AA AA 04 02 00 04 3C BD -> attention_data=0x3C, poor_signal=0x00, attn_upd and pkt_ok each pulse once, one cycle after BD.
- Same packet with checksum BE -> chk_err pulses; attention_data, poor_signal and meditation_data unchanged; no attn_upd.
- Raw-wave packet AA AA 04 80 02 01 F4 88 -> pkt_ok pulses, attn_upd stays 0, attention_data holds.
- Excode row AA AA 03 55 04 50 56 -> pkt_ok pulses, attention_data unchanged (extended code ignored).
- Stream AA AA AA 02 05 28 D2 with idle cycles between bytes -> extra sync tolerated; meditation_data=0x28; pkt_ok pulses.
- PLEN 0xB0 (>169) mid-stream -> parser resyncs, next valid packet decoded. Assert rst after AA AA 04 02 -> outputs return to reset values, and a following full packet decodes correctly.

Source files
------------

// File: rtl/snake_tg_pkg.sv
// Shared types and constants for the ThinkGear packet parser.
package snake_tg_pkg;

    typedef enum logic [2:0] {
        SYNC1,
        SYNC2,
        PLEN,
        CODE,
        VLEN,
        VALUE,
        CHK
    } state_t;

    localparam logic [7:0] SYNC_BYTE      = 8'hAA;
    localparam logic [7:0] EXCODE         = 8'h55;
    localparam logic [7:0] CODE_POOR      = 8'h02;
    localparam logic [7:0] CODE_ATTN      = 8'h04;
    localparam logic [7:0] CODE_MED       = 8'h05;
    localparam logic [7:0] MULTI_BYTE_MIN = 8'h80;
    localparam int         MAX_PLEN       = 169;
    localparam logic [7:0] POOR_RESET     = 8'd200;

endpackage

// File: rtl/tg_packet_parser.sv
// ThinkGear byte-stream decoder: extracts attention, meditation and
// poor-signal values and commits them only from checksum-valid packets.
//
// state | meaning
// SYNC1 | hunting for first 0xAA
// SYNC2 | saw one 0xAA, expecting a second
// PLEN  | expecting payload length (extra 0xAA tolerated)
// CODE  | expecting a row code or an excode prefix
// VLEN  | expecting the length of a multi-byte row
// VALUE | consuming row value byte(s)
// CHK   | expecting the checksum byte
module tg_packet_parser
    import snake_tg_pkg::state_t, snake_tg_pkg::SYNC1, snake_tg_pkg::SYNC2,
           snake_tg_pkg::PLEN, snake_tg_pkg::CODE, snake_tg_pkg::VLEN,
           snake_tg_pkg::VALUE, snake_tg_pkg::CHK, snake_tg_pkg::EXCODE,
           snake_tg_pkg::CODE_POOR, snake_tg_pkg::CODE_ATTN,
           snake_tg_pkg::CODE_MED, snake_tg_pkg::MULTI_BYTE_MIN,
           snake_tg_pkg::POOR_RESET;
#(
    parameter int         MAX_PLEN  = snake_tg_pkg::MAX_PLEN,
    parameter logic [7:0] SYNC_BYTE = snake_tg_pkg::SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] attention_data,
    output logic [7:0] meditation_data,
    output logic [7:0] poor_signal,
    output logic       attn_upd,
    output logic       pkt_ok,
    output logic       chk_err
);

    state_t     state, state_nxt;
    logic [7:0] remaining;
    logic [7:0] sum;
    logic [7:0] code;
    logic [7:0] vcount;
    logic [1:0] excode_lvl;
    logic       single_row;
    logic [7:0] attn_pend, med_pend, poor_pend;
    logic       attn_vld, med_vld, poor_vld;
    logic       payload_byte;
    logic       last_byte;
    logic       plen_legal;

    assign payload_byte = rx_valid && (state == CODE || state == VLEN || state == VALUE);
    // The byte being consumed drains the payload counter to zero.
    assign last_byte    = (remaining == 8'd1);
    assign plen_legal   = (rx_data != SYNC_BYTE) && (int'(rx_data) <= MAX_PLEN);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SYNC1;
        else      state <= state_nxt;
    end

    // Next-state decode; only a strobed byte can move the FSM.
    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            case (state)
                SYNC1: if (rx_data == SYNC_BYTE) state_nxt = SYNC2;
                SYNC2: state_nxt = (rx_data == SYNC_BYTE) ? PLEN : SYNC1;
                PLEN: begin
                    if (rx_data == SYNC_BYTE)          state_nxt = PLEN;
                    else if (int'(rx_data) > MAX_PLEN) state_nxt = SYNC1;
                    else if (rx_data == 8'd0)          state_nxt = CHK;
                    else                               state_nxt = CODE;
                end
                CODE: begin
                    if (last_byte)                       state_nxt = CHK;
                    else if (rx_data == EXCODE)          state_nxt = CODE;
                    else if (rx_data < MULTI_BYTE_MIN)   state_nxt = VALUE;
                    else                                 state_nxt = VLEN;
                end
                VLEN: begin
                    if (last_byte)             state_nxt = CHK;
                    else if (rx_data == 8'd0)  state_nxt = CODE;
                    else                       state_nxt = VALUE;
                end
                VALUE: begin
                    if (last_byte)                            state_nxt = CHK;
                    else if (single_row || vcount == 8'd1)    state_nxt = CODE;
                    else                                      state_nxt = VALUE;
                end
                CHK:     state_nxt = SYNC1;
                default: state_nxt = SYNC1;
            endcase
        end
    end

    // Payload accumulation, pending capture and registered commit/pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining       <= 8'd0;
            sum             <= 8'd0;
            code            <= 8'd0;
            vcount          <= 8'd0;
            excode_lvl      <= 2'd0;
            single_row      <= 1'b0;
            attn_pend       <= 8'd0;
            med_pend        <= 8'd0;
            poor_pend       <= 8'd0;
            attn_vld        <= 1'b0;
            med_vld         <= 1'b0;
            poor_vld        <= 1'b0;
            attention_data  <= 8'd0;
            meditation_data <= 8'd0;
            poor_signal     <= POOR_RESET;
            attn_upd        <= 1'b0;
            pkt_ok          <= 1'b0;
            chk_err         <= 1'b0;
        end else begin
            attn_upd <= 1'b0;
            pkt_ok   <= 1'b0;
            chk_err  <= 1'b0;
            if (payload_byte) begin
                sum       <= sum + rx_data;
                remaining <= remaining - 8'd1;
            end
            if (rx_valid) begin
                case (state)
                    PLEN: begin
                        // Zero-length packets also start from a clean sum so
                        // stale pending values can never be committed.
                        if (plen_legal) begin
                            remaining  <= rx_data;
                            sum        <= 8'd0;
                            excode_lvl <= 2'd0;
                            attn_vld   <= 1'b0;
                            med_vld    <= 1'b0;
                            poor_vld   <= 1'b0;
                        end
                    end
                    CODE: begin
                        if (rx_data == EXCODE) begin
                            if (excode_lvl != 2'd3) excode_lvl <= excode_lvl + 2'd1;
                        end else begin
                            code       <= rx_data;
                            single_row <= (rx_data < MULTI_BYTE_MIN);
                        end
                    end
                    VLEN: begin
                        vcount <= rx_data;
                        if (rx_data == 8'd0) excode_lvl <= 2'd0;
                    end
                    VALUE: begin
                        if (single_row) begin
                            excode_lvl <= 2'd0;
                            if (excode_lvl == 2'd0) begin
                                if (code == CODE_ATTN) begin
                                    attn_pend <= rx_data;
                                    attn_vld  <= 1'b1;
                                end
                                if (code == CODE_MED) begin
                                    med_pend <= rx_data;
                                    med_vld  <= 1'b1;
                                end
                                if (code == CODE_POOR) begin
                                    poor_pend <= rx_data;
                                    poor_vld  <= 1'b1;
                                end
                            end
                        end else begin
                            vcount <= vcount - 8'd1;
                            if (vcount == 8'd1) excode_lvl <= 2'd0;
                        end
                    end
                    CHK: begin
                        if (rx_data == ~sum) begin
                            if (attn_vld) attention_data  <= attn_pend;
                            if (med_vld)  meditation_data <= med_pend;
                            if (poor_vld) poor_signal     <= poor_pend;
                            attn_upd <= attn_vld;
                            pkt_ok   <= 1'b1;
                        end else begin
                            chk_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tg_packet_parser.sv
// Bench for tg_packet_parser: directed packet table, reset-mid-packet
// sequence, then randomly generated packets checked against a model that
// derives results from the packet's row list rather than re-parsing bytes.
module tb_tg_packet_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic [7:0] attention_data, meditation_data, poor_signal;
    logic       attn_upd, pkt_ok, chk_err;

    tg_packet_parser dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .attention_data  (attention_data),
        .meditation_data (meditation_data),
        .poor_signal     (poor_signal),
        .attn_upd        (attn_upd),
        .pkt_ok          (pkt_ok),
        .chk_err         (chk_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Pulse counters observed on the falling edge.
    int n_ok = 0, n_err = 0, n_upd = 0;
    int e_ok = 0, e_err = 0, e_upd = 0;
    always @(negedge clk) begin
        if (pkt_ok)   n_ok  <= n_ok + 1;
        if (chk_err)  n_err <= n_err + 1;
        if (attn_upd) n_upd <= n_upd + 1;
    end

    logic [7:0] exp_attn = 8'd0, exp_med = 8'd0, exp_poor = 8'd200;

    typedef struct {
        logic [95:0] bytes;   // first byte in the MSBs
        int          n;
        int          gap;
        logic [7:0]  attn, med, poor;
        logic        ok, err, upd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    // Called on the falling edge right after the checksum byte was taken.
    task automatic check_outs(input string tag, input logic ok, input logic err, input logic upd);
        check({tag, " attention"},  int'(attention_data),  int'(exp_attn));
        check({tag, " meditation"}, int'(meditation_data), int'(exp_med));
        check({tag, " poor"},       int'(poor_signal),     int'(exp_poor));
        check({tag, " pkt_ok"},     int'(pkt_ok),          int'(ok));
        check({tag, " chk_err"},    int'(chk_err),         int'(err));
        check({tag, " attn_upd"},   int'(attn_upd),        int'(upd));
    endtask

    task automatic check_counts(input string tag);
        @(negedge clk);
        @(negedge clk);
        check({tag, " pkt_ok count"},   n_ok,  e_ok);
        check({tag, " chk_err count"},  n_err, e_err);
        check({tag, " attn_upd count"}, n_upd, e_upd);
    endtask

    task automatic rand_packet(input int idx);
        logic [7:0] pl[$];
        logic [7:0] rc[$];
        logic [7:0] rv[$];
        int         rp[$];
        int         rows, ex, kind, len, keep, junk, nsync;
        logic [7:0] c, v, s, chk, b;
        logic       good, upd;
        rows = $urandom_range(0, 6);
        for (int r = 0; r < rows; r++) begin
            ex   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            kind = $urandom_range(0, 5);
            for (int e = 0; e < ex; e++) pl.push_back(8'h55);
            if (kind <= 3) begin
                case (kind)
                    0: c = 8'h02;
                    1: c = 8'h04;
                    2: c = 8'h05;
                    default: begin
                        c = 8'($urandom_range(0, 127));
                        if (c == 8'h55) c = 8'h03;
                    end
                endcase
                pl.push_back(c);
                v = 8'($urandom);
                if (ex == 0 && (c == 8'h02 || c == 8'h04 || c == 8'h05)) begin
                    rc.push_back(c);
                    rv.push_back(v);
                    rp.push_back(pl.size());
                end
                pl.push_back(v);
            end else begin
                len = $urandom_range(0, 3);
                pl.push_back(8'h80 | 8'($urandom_range(0, 127)));
                pl.push_back(8'(len));
                for (int k = 0; k < len; k++) pl.push_back(8'($urandom));
            end
        end
        keep = pl.size();
        if ($urandom_range(0, 3) == 0) keep = $urandom_range(0, pl.size());
        s = 8'd0;
        for (int k = 0; k < keep; k++) s = s + pl[k];
        good = ($urandom_range(0, 3) != 0);
        chk  = ~s;
        if (!good) chk = chk ^ 8'($urandom_range(1, 255));

        junk = $urandom_range(0, 2);
        for (int k = 0; k < junk; k++) begin
            b = 8'($urandom);
            if (b == 8'hAA) b = 8'h00;
            send(b, $urandom_range(0, 2));
        end
        nsync = ($urandom_range(0, 3) == 0) ? 3 : 2;
        for (int k = 0; k < nsync; k++) send(8'hAA, $urandom_range(0, 2));
        send(8'(keep), $urandom_range(0, 2));
        for (int k = 0; k < keep; k++) send(pl[k], $urandom_range(0, 2));
        send(chk, 0);

        upd = 1'b0;
        if (good) begin
            for (int k = 0; k < rc.size(); k++) begin
                if (rp[k] < keep) begin
                    if (rc[k] == 8'h02) exp_poor = rv[k];
                    if (rc[k] == 8'h05) exp_med  = rv[k];
                    if (rc[k] == 8'h04) begin
                        exp_attn = rv[k];
                        upd      = 1'b1;
                    end
                end
            end
            e_ok++;
        end else begin
            e_err++;
        end
        if (upd) e_upd++;
        check_outs($sformatf("rand%0d", idx), good, !good, upd);
        check_counts($sformatf("rand%0d", idx));
    endtask

    initial begin
        vecs[0] = '{{64'hAAAA_0402_0004_3CBD, 32'h0}, 8, 0, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{{64'hAAAA_0402_0004_3CBE, 32'h0}, 8, 1, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{{64'hAAAA_0480_0201_F488, 32'h0}, 8, 0, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{{56'hAAAA_0355_0450_56, 40'h0},   7, 0, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{{56'hAAAA_AA02_0528_D2, 40'h0},   7, 2, 8'h3C, 8'h28, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{{88'hAAAA_B0AA_AA04_027F_0440_3A, 8'h0}, 11, 0, 8'h40, 8'h28, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{{56'hAAAA_0302_0504_F4, 40'h0},   7, 1, 8'h40, 8'h28, 8'h05, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{{32'hAAAA_00FF, 64'h0},           4, 0, 8'h40, 8'h28, 8'h05, 1'b1, 1'b0, 1'b0};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset attention",  int'(attention_data),  0);
        check("reset meditation", int'(meditation_data), 0);
        check("reset poor",       int'(poor_signal),     200);
        check("reset pulses",     int'({attn_upd, pkt_ok, chk_err}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                send(vecs[i].bytes[95 - 8*k -: 8], (k == vecs[i].n - 1) ? 0 : vecs[i].gap);
            exp_attn = vecs[i].attn;
            exp_med  = vecs[i].med;
            exp_poor = vecs[i].poor;
            if (vecs[i].ok)  e_ok++;
            if (vecs[i].err) e_err++;
            if (vecs[i].upd) e_upd++;
            check_outs($sformatf("vec%0d", i), vecs[i].ok, vecs[i].err, vecs[i].upd);
            check_counts($sformatf("vec%0d", i));
        end

        // Reset in the middle of a packet, then a full packet from scratch.
        send(8'hAA, 0);
        send(8'hAA, 0);
        send(8'h04, 0);
        send(8'h02, 0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst attention",  int'(attention_data),  0);
        check("midrst meditation", int'(meditation_data), 0);
        check("midrst poor",       int'(poor_signal),     200);
        check("midrst pulses",     int'({attn_upd, pkt_ok, chk_err}), 0);
        rst = 1'b1;
        @(negedge clk);
        exp_attn = 8'h3C;
        exp_med  = 8'h00;
        exp_poor = 8'h00;
        send(8'hAA, 0); send(8'hAA, 0); send(8'h04, 0); send(8'h02, 0);
        send(8'h00, 0); send(8'h04, 0); send(8'h3C, 0); send(8'hBD, 0);
        e_ok++;
        e_upd++;
        check_outs("post_reset", 1'b1, 1'b0, 1'b1);
        check_counts("post_reset");

        for (int i = 0; i < 60; i++) rand_packet(i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
